// File: rtl/seq_event_logger_pkg.sv
// Shared constants and helpers for the sequence-detector event logger.
// Defaults cover the common 8-entry, 16-bit-timestamp configuration.
package seq_event_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/seq_event_logger_if.sv
// Valid/ready read port through which queued detection timestamps are offered.
// The logger is the master; the host or monitor is the slave.
interface seq_event_logger_if
    import seq_event_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);
    logic            ev_valid;
    logic [TS_W-1:0] ev_ts;
    logic            ev_ready;

    modport master (output ev_valid, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_ts, output ev_ready);

endinterface

// File: rtl/seq_event_logger_fifo.sv
// Single-clock FIFO with a registered head entry, so valid and data never
// depend combinationally on the current push or pop.
module evt_fifo
    import seq_event_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = TS_W_DEF,
    localparam int PW    = ptr_w(DEPTH),
    localparam int LW    = PW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          head_valid,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_r;
    logic [PW-1:0] rd_r;
    logic [LW-1:0] level_r;
    logic          head_valid_r;
    logic [DW-1:0] head_r;

    logic          pop_ok_s;
    logic          push_ok_s;
    logic [PW-1:0] rd_nxt_s;
    logic [LW-1:0] level_nxt_s;
    logic [DW-1:0] head_nxt_s;

    // Next-state for occupancy and the head register; a push into a one-entry
    // result lands directly on the head, otherwise the head comes from memory.
    always_comb begin
        pop_ok_s    = pop && (level_r != {LW{1'b0}});
        push_ok_s   = push && ((level_r != LW'(DEPTH)) || pop_ok_s);
        rd_nxt_s    = rd_r + PW'(pop_ok_s);
        level_nxt_s = level_r + LW'(push_ok_s) - LW'(pop_ok_s);
        head_nxt_s  = {DW{1'b0}};
        if (level_nxt_s == {LW{1'b0}}) begin
            head_nxt_s = {DW{1'b0}};
        end else if (push_ok_s && (rd_nxt_s == wr_r)) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pointer, occupancy and head registers; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_r         <= {PW{1'b0}};
            rd_r         <= {PW{1'b0}};
            level_r      <= {LW{1'b0}};
            head_valid_r <= 1'b0;
            head_r       <= {DW{1'b0}};
        end else if (flush) begin
            wr_r         <= {PW{1'b0}};
            rd_r         <= {PW{1'b0}};
            level_r      <= {LW{1'b0}};
            head_valid_r <= 1'b0;
            head_r       <= {DW{1'b0}};
        end else begin
            wr_r         <= wr_r + PW'(push_ok_s);
            rd_r         <= rd_nxt_s;
            level_r      <= level_nxt_s;
            head_valid_r <= (level_nxt_s != {LW{1'b0}});
            head_r       <= head_nxt_s;
        end
    end

    // Storage array; contents outside the live window are never observed.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_r] <= din;
        end
    end

    assign full       = (level_r == LW'(DEPTH));
    assign empty      = (level_r == {LW{1'b0}});
    assign level      = level_r;
    assign head_valid = head_valid_r;
    assign head       = head_r;

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps every detector pulse and queues it for a host, keeping
// saturating detection/drop counts and a sticky overflow flag.
module seq_event_logger
    import seq_event_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int TS_W  = TS_W_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int LW    = ptr_w(DEPTH) + 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                det,
    input  logic                clr,
    seq_event_logger_if.master  ev,
    output logic [LW-1:0]       level,
    output logic [CNT_W-1:0]    det_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  ts_r;
    logic [CNT_W-1:0] det_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             ovf_r;

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             head_valid_s;
    logic [TS_W-1:0]  head_s;

    // A full queue still accepts an event when the head leaves in the same cycle.
    always_comb begin
        pop_s  = ev.ev_ready && !empty_s;
        push_s = det && (!full_s || pop_s);
        drop_s = det && full_s && !pop_s;
    end

    // Free-running timestamp; clr deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1'b1);
        end
    end

    // Saturating statistics and sticky overflow; clr wins over a coincident event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_cnt_r  <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
        end else if (clr) begin
            det_cnt_r  <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            if (det && (det_cnt_r != CNT_MAX)) begin
                det_cnt_r <= det_cnt_r + CNT_W'(1'b1);
            end else begin
                det_cnt_r <= det_cnt_r;
            end
            if (drop_s && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1'b1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            ovf_r <= ovf_r | drop_s;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .DW    (TS_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (clr),
        .push       (push_s),
        .pop        (pop_s),
        .din        (ts_r),
        .full       (full_s),
        .empty      (empty_s),
        .level      (level),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    assign ev.ev_valid = head_valid_s;
    assign ev.ev_ts    = head_s;
    assign det_cnt     = det_cnt_r;
    assign drop_cnt    = drop_cnt_r;
    assign ovf         = ovf_r;

endmodule

// File: tb/tb_seq_event_logger.sv
// Randomised and directed bench for seq_event_logger: two instances (wide and
// narrow timestamp/counter widths) share stimulus and one queue-based model.
module tb_seq_event_logger;
    import seq_event_pkg::*;

    localparam int DEPTH = 8;
    localparam int TSA   = 16;
    localparam int CNTA  = 8;
    localparam int TSB   = 4;
    localparam int CNTB  = 3;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst, det, clr, ready;

    always #5 clk = ~clk;

    seq_event_logger_if #(.TS_W(TSA)) ifa ();
    seq_event_logger_if #(.TS_W(TSB)) ifb ();
    assign ifa.ev_ready = ready;
    assign ifb.ev_ready = ready;

    logic [LW-1:0]   a_level, b_level;
    logic [CNTA-1:0] a_det_cnt, a_drop_cnt;
    logic [CNTB-1:0] b_det_cnt, b_drop_cnt;
    logic            a_ovf, b_ovf;

    seq_event_logger #(.DEPTH(DEPTH), .TS_W(TSA), .CNT_W(CNTA)) dut_a (
        .clk(clk), .rst(rst), .det(det), .clr(clr), .ev(ifa.master),
        .level(a_level), .det_cnt(a_det_cnt), .drop_cnt(a_drop_cnt), .ovf(a_ovf));

    seq_event_logger #(.DEPTH(DEPTH), .TS_W(TSB), .CNT_W(CNTB)) dut_b (
        .clk(clk), .rst(rst), .det(det), .clr(clr), .ev(ifb.master),
        .level(b_level), .det_cnt(b_det_cnt), .drop_cnt(b_drop_cnt), .ovf(b_ovf));

    // Reference model: queue of unbounded timestamps plus unbounded counts.
    int q[$];
    int m_ts, m_dets, m_drops;
    bit m_ovf;
    int checks = 0;
    int errors = 0;

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int ha, hb;
        ha = (q.size() > 0) ? (q[0] & ((1 << TSA) - 1)) : 0;
        hb = (q.size() > 0) ? (q[0] & ((1 << TSB) - 1)) : 0;
        chk("a_valid", 32'(ifa.ev_valid), 32'(q.size() > 0));
        chk("a_ts",    32'(ifa.ev_ts),    32'(ha));
        chk("a_level", 32'(a_level),      32'(q.size()));
        chk("a_det",   32'(a_det_cnt),    32'(sat(m_dets, CNTA)));
        chk("a_drop",  32'(a_drop_cnt),   32'(sat(m_drops, CNTA)));
        chk("a_ovf",   32'(a_ovf),        32'(m_ovf));
        chk("b_valid", 32'(ifb.ev_valid), 32'(q.size() > 0));
        chk("b_ts",    32'(ifb.ev_ts),    32'(hb));
        chk("b_level", 32'(b_level),      32'(q.size()));
        chk("b_det",   32'(b_det_cnt),    32'(sat(m_dets, CNTB)));
        chk("b_drop",  32'(b_drop_cnt),   32'(sat(m_drops, CNTB)));
        chk("b_ovf",   32'(b_ovf),        32'(m_ovf));
    endtask

    task automatic model_edge();
        bit do_pop;
        if (clr) begin
            q.delete();
            m_dets  = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            do_pop = (q.size() > 0) && ready;
            if (det) begin
                m_dets++;
                if (!(q.size() < DEPTH || do_pop)) begin
                    m_drops++;
                    m_ovf = 1'b1;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (det && (q.size() < DEPTH)) begin
                if (!(m_drops > 0 && m_ovf && q.size() == DEPTH)) q.push_back(m_ts);
            end
        end
        m_ts++;
    endtask

    task automatic step(input bit d, input bit c, input bit r);
        det = d; clr = c; ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_dets = 0; m_drops = 0; m_ovf = 1'b0;
    endtask

    // Asserts reset between edges, checks outputs clear before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int rp;
        bit d, c, r;
        rst = 1'b1; det = 1'b0; clr = 1'b0; ready = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Isolated events at ts 3, 7, 12 with the consumer always ready.
        while (m_ts < 13) begin
            t = m_ts;
            step(t == 3 || t == 7 || t == 12, 1'b0, 1'b1);
            if (t == 3 || t == 7 || t == 12) chk("t1_ts", 32'(ifa.ev_ts), 32'(t));
        end
        chk("t1_det", 32'(a_det_cnt), 32'd3);
        chk("t1_drop", 32'(a_drop_cnt), 32'd0);
        chk("t1_ovf", 32'(a_ovf), 32'd0);

        // Held det overflows the queue; drain afterwards.
        while (m_ts < 19) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        chk("t2_level", 32'(a_level), 32'd8);
        chk("t2_drop", 32'(a_drop_cnt), 32'd2);
        chk("t2_det", 32'(a_det_cnt), 32'd10);
        chk("t2_ovf", 32'(a_ovf), 32'd1);
        chk("t2_head", 32'(ifa.ev_ts), 32'd20);
        chk("t2_head_b", 32'(ifb.ev_ts), 32'd4);
        step(1'b0, 1'b0, 1'b1);
        chk("t2_next", 32'(ifa.ev_ts), 32'd21);
        repeat (7) step(1'b0, 1'b0, 1'b1);
        chk("t2_empty", 32'(a_level), 32'd0);
        chk("t2_ovf_sticky", 32'(a_ovf), 32'd1);

        // Full queue with simultaneous event and pop.
        repeat (8) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t3_level", 32'(a_level), 32'd8);
        chk("t3_drop", 32'(a_drop_cnt), 32'd2);
        repeat (9) step(1'b0, 1'b0, 1'b1);

        // Narrow timestamp wrap from 15 to 0.
        while ((m_ts % 16) != 15) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_first", 32'(ifb.ev_ts), 32'd15);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_second", 32'(ifb.ev_ts), 32'd0);
        step(1'b0, 1'b0, 1'b1);

        // clr with a coincident event while entries are queued.
        repeat (5) step(1'b1, 1'b0, 1'b0);
        t = m_ts;
        step(1'b1, 1'b1, 1'b0);
        chk("t5_level", 32'(a_level), 32'd0);
        chk("t5_valid", 32'(ifa.ev_valid), 32'd0);
        chk("t5_det", 32'(a_det_cnt), 32'd0);
        chk("t5_ovf", 32'(a_ovf), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_ts_runs", 32'(ifa.ev_ts), 32'(t + 1));

        // Asynchronous reset with entries queued.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        chk("t6_ts0", 32'(ifa.ev_ts), 32'd0);

        // Narrow detection counter saturates.
        repeat (9) step(1'b1, 1'b0, 1'b1);
        chk("t7_sat_b", 32'(b_det_cnt), 32'd7);
        chk("t7_a", 32'(a_det_cnt), 32'd10);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        chk("t7_hold_b", 32'(b_det_cnt), 32'd7);

        // Random traffic with alternating consumer throughput.
        rp = 20;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 250) == 0) rp = (rp == 20) ? 85 : 20;
            d = ($urandom_range(0, 99) < 60);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 99) < rp);
            if ($urandom_range(0, 799) == 0) do_reset();
            else step(d, c, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
